// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the sequential fixed-point multiplier.
// Holds the default Q-format geometry, the controller state encoding and
// handy Q-format constants used by fp_mul and its post-processing stage.
// Optional rounding is selected with the FP_MUL_ROUND_EN macro in fp_mul_post.
package fp_pkg;

    // Default operand geometry: Q8.24 in a 32-bit two's complement word
    localparam int FP_WIDTH = 32;
    localparam int FP_FBITS = 24;

    // Bit counter must be able to count 0 .. WIDTH
    localparam int FP_CNT_W = $clog2(FP_WIDTH + 1);

    // Q-format reference values at the default geometry
    localparam logic [FP_WIDTH-1:0] FP_ONE = FP_WIDTH'(1) << FP_FBITS;
    localparam logic [FP_WIDTH-1:0] FP_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic [FP_WIDTH-1:0] FP_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

    // Controller states: wait for start, iterate over multiplier bits,
    // then scale/saturate/sign the accumulated magnitude
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        POST = 2'd2
    } fp_state_e;

endpackage

// File: rtl/fp_mul_post.sv
// fp_mul_post: combinational result stage of the fixed-point multiplier.
// Takes the unsigned 2*WIDTH product magnitude and the result sign, drops
// the extra FBITS fractional bits, saturates to the signed Q range and
// applies the sign. When FP_MUL_ROUND_EN is defined the magnitude is rounded
// to nearest (ties away from zero) before scaling; otherwise it is truncated
// toward zero.
module fp_mul_post
    import fp_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int FBITS = FP_FBITS
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               sign_i,
    output logic [WIDTH-1:0]   p_next_o,
    output logic               ovf_next_o
);

    // Width of the scaled magnitude and of the bits above the result word
    localparam int MW = 2*WIDTH - FBITS;
    localparam int HW = MW - WIDTH;

    logic [2*WIDTH-1:0] rounded;
    logic [MW-1:0]      mag;
    logic [HW-1:0]      magHigh;
    logic [FBITS-1:0]   unusedFrac;
    logic               posOvf;
    logic               negOvf;

`ifdef FP_MUL_ROUND_EN
    // Half an LSB of the result added before scaling; the magnitude is at
    // most 2^(2*WIDTH-2), so this sum can never wrap
    assign rounded = acc_i + ((2*WIDTH)'(1) << (FBITS - 1));
`else
    // Plain truncation toward zero
    assign rounded = acc_i;
`endif

    assign mag        = rounded[2*WIDTH-1:FBITS];
    assign magHigh    = mag[MW-1:WIDTH];
    assign unusedFrac = rounded[FBITS-1:0];

    // Positive results may reach 2^(WIDTH-1)-1, negative ones 2^(WIDTH-1);
    // anything larger clamps to the matching end of the range
    always_comb begin
        posOvf     = (|magHigh) | mag[WIDTH-1];
        negOvf     = (|magHigh) | (mag[WIDTH-1] & (|mag[WIDTH-2:0]));
        p_next_o   = '0;
        ovf_next_o = 1'b0;
        if (sign_i) begin
            if (negOvf) begin
                p_next_o   = {1'b1, {(WIDTH-1){1'b0}}};
                ovf_next_o = 1'b1;
            end else begin
                p_next_o   = '0 - mag[WIDTH-1:0];
            end
        end else begin
            if (posOvf) begin
                p_next_o   = {1'b0, {(WIDTH-1){1'b1}}};
                ovf_next_o = 1'b1;
            end else begin
                p_next_o   = mag[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_mul.sv
// fp_mul: sequential signed fixed-point multiplier, Q(WIDTH-FBITS).FBITS.
// Sign-magnitude shift-and-add, one multiplier bit per clock, with a fixed
// latency of WIDTH+1 clocks from the start edge to the valid pulse.
// Rounding of the result is enabled by defining FP_MUL_ROUND_EN
// (see fp_mul_post); the latency is the same in both builds.
module fp_mul
    import fp_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int FBITS = FP_FBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic             ovf,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] p
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    fp_state_e          state_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   p_q;
    logic               ovf_q;
    logic               valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   absX;
    logic [WIDTH-1:0]   absY;
    logic [WIDTH-1:0]   pNext;
    logic               ovfNext;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which is still exact as an unsigned WIDTH-bit number
    always_comb begin
        absX = x[WIDTH-1] ? ('0 - x) : x;
        absY = y[WIDTH-1] ? ('0 - y) : y;
    end

    // Partial-product step: add the shifted multiplicand when the current
    // multiplier bit is set
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    fp_mul_post #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_post (
        .acc_i      (acc_q),
        .sign_i     (sign_q),
        .p_next_o   (pNext),
        .ovf_next_o (ovfNext)
    );

    // Controller and datapath registers; a start during CALC/POST is
    // ignored, and a start in the valid cycle is accepted because the
    // controller is already back in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        sign_q   <= x[WIDTH-1] ^ y[WIDTH-1];
                        mcand_q  <= {{WIDTH{1'b0}}, absX};
                        mplier_q <= absY;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= POST;
                    end
                end
                POST: begin
                    p_q     <= pNext;
                    ovf_q   <= ovfNext;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign p     = p_q;

endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: self-checking bench for fp_mul at the default Q8.24 geometry.
// Expected products come from a 64-bit integer reference model; the
// FP_MUL_ROUND_EN macro selects rounding in both the model and the design.
module tb_fp_mul;

    localparam int WIDTH   = 32;
    localparam int FBITS   = 24;
    localparam int LATENCY = WIDTH + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] p;
    logic        busy;
    logic        valid;
    logic        ovf;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_mul #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .valid (valid),
        .ovf   (ovf),
        .x     (x),
        .y     (y),
        .p     (p)
    );

    // Reference: exact signed product, magnitude, optional rounding,
    // scaling by 2^-FBITS, then saturation to the signed result range
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] ep, output logic eo);
        longint prod;
        longint mag;
        longint m;
        bit     neg;
        prod = longint'($signed(a)) * longint'($signed(b));
        neg  = a[31] ^ b[31];
        mag  = (prod < 0) ? -prod : prod;
`ifdef FP_MUL_ROUND_EN
        mag  = mag + (longint'(1) << (FBITS - 1));
`endif
        m    = mag >>> FBITS;
        if (!neg && m > (longint'(1) << (WIDTH - 1)) - 1) begin
            ep = 32'h7FFF_FFFF;
            eo = 1'b1;
        end else if (neg && m > (longint'(1) << (WIDTH - 1))) begin
            ep = 32'h8000_0000;
            eo = 1'b1;
        end else begin
            ep = neg ? 32'(-m) : 32'(m);
            eo = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the start pulse is captured on the next rising edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        x     = a;
        y     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until valid, bounded, then checks timing and result
    task automatic waitResult(input string tag, input int expLat,
                              input logic [31:0] expP, input logic expOvf);
        int cyc    = 0;
        bit busyOk = 1'b1;
        while (valid !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, ".latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, ".busyHigh"}, 64'(busyOk), 64'd1);
        checkOutput({tag, ".busyLow"}, 64'(busy), 64'd0);
        checkOutput({tag, ".p"}, 64'(p), 64'(expP));
        checkOutput({tag, ".ovf"}, 64'(ovf), 64'(expOvf));
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ep;
        logic        eo;
        refModel(a, b, ep, eo);
        applyStimulus(a, b);
        waitResult(tag, LATENCY, ep, eo);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0]        ep;
        logic               eo;
        logic signed [31:0] ra;
        logic signed [31:0] rb;
        bit                 sawValid;

        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.valid", 64'(valid), 64'd0);
        checkOutput("reset.p", 64'(p), 64'd0);
        checkOutput("reset.ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        runOp("half", 32'h0080_0000, 32'h0008_0000);
        checkOutput("half.const", 64'(p), 64'h0004_0000);
        @(negedge clk);
        checkOutput("half.validPulse", 64'(valid), 64'd0);
        checkOutput("half.pHeld", 64'(p), 64'h0004_0000);

        runOp("negThree", 32'hFE80_0000, 32'h0200_0000);
        checkOutput("negThree.const", 64'(p), 64'hFD00_0000);
        runOp("minExact", 32'h8000_0000, 32'h0100_0000);
        checkOutput("minExact.const", 64'(p), 64'h8000_0000);
        runOp("posSat", 32'h6400_0000, 32'h0200_0000);
        checkOutput("posSat.const", 64'(p), 64'h7FFF_FFFF);
        runOp("minTimesNegOne", 32'h8000_0000, 32'hFF00_0000);
        checkOutput("minTimesNegOne.ovf", 64'(ovf), 64'd1);
        runOp("roundPos", 32'h0000_0001, 32'h0080_0000);
        runOp("roundNeg", 32'hFFFF_FFFF, 32'h0080_0000);
        runOp("zero", 32'h0000_0000, 32'h8000_0000);

        // A second start while busy, with new operands, must not disturb the result
        refModel(32'h0100_0000, 32'h0300_0000, ep, eo);
        applyStimulus(32'h0100_0000, 32'h0300_0000);
        repeat (4) @(negedge clk);
        x     = 32'h7F00_0000;
        y     = 32'h7F00_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitResult("ignoreStart", LATENCY - 5, ep, eo);
        checkOutput("ignoreStart.const", 64'(p), 64'h0300_0000);

        // Reset mid-operation, together with start: abort without a valid pulse
        applyStimulus(32'h0080_0000, 32'h0080_0000);
        repeat (8) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("midReset.busy", 64'(busy), 64'd0);
        checkOutput("midReset.valid", 64'(valid), 64'd0);
        checkOutput("midReset.p", 64'(p), 64'd0);
        checkOutput("midReset.ovf", 64'(ovf), 64'd0);
        rst      = 1'b0;
        start    = 1'b0;
        sawValid = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (valid === 1'b1) sawValid = 1'b1;
        end
        checkOutput("midReset.noValid", 64'(sawValid), 64'd0);

        runOp("fresh", 32'hFF40_0000, 32'h00C0_0000);

        // Back-to-back: the next start is issued in the valid cycle
        runOp("b2bFirst", 32'h0280_0000, 32'hFD00_0000);
        refModel(32'h0080_0000, 32'h0080_0000, ep, eo);
        applyStimulus(32'h0080_0000, 32'h0080_0000);
        waitResult("b2bSecond", LATENCY, ep, eo);
        checkOutput("b2bSecond.const", 64'(p), 64'h0040_0000);

        // Random operands over a spread of magnitudes
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            ra = ra >>> $urandom_range(0, 30);
            rb = rb >>> $urandom_range(0, 30);
            runOp($sformatf("rand%0d", i), ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
